regfile_mp: RTL and testbench

Parametrised multi-read-port register file: the next generation of the team's 8x4 dual-port register file. Generalised in data width, depth and read-port count. Adds the following, which the fixed 8x4 block does not have:
- selectable registered or combinational reads;
- write-to-read bypass;
- optional hardwired-zero entry 0;
- a sequential sweep-clear engine with a busy flag;
- error pulses for illegal writes.

It sits beside datapath blocks as their architectural register store.

---
 rtl/regfile_mp.sv | 142 ++++++++++++++
 tb/tb_regfile_mp.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with several read ports.
// Reads can be combinational or registered. A same-cycle write can be
// forwarded to reads, and entry 0 can be hardwired to zero. A sequential
// sweep engine clears every entry, one per cycle, on request. Writes that
// cannot be accepted are discarded and reported one cycle later.
//
// Ports:
//   clk       - clock; all state updates on the rising edge
//   rst       - asynchronous active-high reset
//   wr_en     - write strobe
//   wr_addr   - write address (ADDR_W bits)
//   wr_data   - write data (DATA_W bits)
//   rd_addr   - packed read addresses; port p uses [p*ADDR_W +: ADDR_W]
//   rd_data   - packed read data; port p uses [p*DATA_W +: DATA_W]
//   clr_req   - start a sweep clear of all entries
//   clr_busy  - high while the sweep clear runs
//   wr_drop   - one-cycle pulse: the previous cycle's write was discarded
module regfile_mp #(
  parameter int DATA_W   = 4,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int N_RD     = 2,
  parameter int RD_REG   = 0,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     wr_drop
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic                wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0]   rd_q [N_RD];
  logic [DATA_W-1:0]   rd_val [N_RD];
  logic                wr_legal;

  // A write is accepted only for an in-range address, outside the sweep,
  // and never to a hardwired-zero entry 0.
  always_comb begin
    wr_legal = wr_en
             && (32'(wr_addr) < 32'(DEPTH))
             && (state_q == IDLE)
             && !((ZERO_REG != 0) && (wr_addr == '0));
    wr_drop_d = wr_en && !wr_legal;
  end

  // Storage next-state and the sweep FSM. Accepted writes only happen in
  // IDLE, so they never collide with the sweep's clearing write.
  always_comb begin
    mem_d   = mem_q;
    state_d = state_q;
    ptr_d   = ptr_q;
    if (wr_legal) begin
      mem_d[wr_addr] = wr_data;
    end
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        mem_d[ptr_q] = '0;
        if (ptr_q == LAST_IDX) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Per-port read value. Out-of-range addresses and a hardwired entry 0
  // read as zero; an accepted same-cycle write is forwarded when enabled.
  // The sweep's clearing write is deliberately not forwarded.
  always_comb begin
    for (int p = 0; p < N_RD; p++) begin
      logic [ADDR_W-1:0] ra;
      ra = rd_addr[p*ADDR_W +: ADDR_W];
      if (!(32'(ra) < 32'(DEPTH))) begin
        rd_val[p] = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_val[p] = '0;
      end else if ((BYPASS != 0) && wr_legal && (ra == wr_addr)) begin
        rd_val[p] = wr_data;
      end else begin
        rd_val[p] = mem_q[ra];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      wr_drop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      for (int p = 0; p < N_RD; p++) begin
        rd_q[p] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_drop_q <= wr_drop_d;
      mem_q     <= mem_d;
      for (int p = 0; p < N_RD; p++) begin
        rd_q[p] <= rd_val[p];
      end
    end
  end

  for (genvar p = 0; p < N_RD; p++) begin : g_rd
    assign rd_data[p*DATA_W +: DATA_W] = (RD_REG != 0) ? rd_q[p] : rd_val[p];
  end

  assign clr_busy = (state_q == CLEAR);
  assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp. Four instances share one input stimulus:
//   0: defaults (combinational read, bypass on)
//   1: bypass off
//   2: registered read, bypass on
//   3: DEPTH=6 with hardwired-zero entry 0
// A behavioural model tracks contents, sweep progress and drop pulses.
module tb_regfile_mp;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [5:0] rd_addr;
  logic       clr_req;
  logic [7:0] rd_o [4];
  logic       busy_o [4];
  logic       drop_o [4];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state, one set per instance.
  int cfg_depth [4] = '{8, 8, 8, 6};
  int cfg_byp   [4] = '{1, 0, 1, 1};
  int cfg_rreg  [4] = '{0, 0, 1, 0};
  int cfg_zero  [4] = '{0, 0, 0, 1};
  int mem_m  [4][8];
  bit busy_m [4];
  int ptr_m  [4];
  bit drop_m [4];
  int rdq_m  [4][2];

  regfile_mp u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_o[0]), .clr_req(clr_req),
    .clr_busy(busy_o[0]), .wr_drop(drop_o[0])
  );

  regfile_mp #(.BYPASS(0)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_o[1]), .clr_req(clr_req),
    .clr_busy(busy_o[1]), .wr_drop(drop_o[1])
  );

  regfile_mp #(.RD_REG(1)) u_dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_o[2]), .clr_req(clr_req),
    .clr_busy(busy_o[2]), .wr_drop(drop_o[2])
  );

  regfile_mp #(.DEPTH(6), .ZERO_REG(1)) u_dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_o[3]), .clr_req(clr_req),
    .clr_busy(busy_o[3]), .wr_drop(drop_o[3])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int port_addr(int p);
    return int'(rd_addr[p*3 +: 3]);
  endfunction

  function automatic int port_rd(int k, int p);
    return int'(rd_o[k][p*4 +: 4]);
  endfunction

  function automatic bit legal_m(int k);
    if (!wr_en) return 1'b0;
    if (int'(wr_addr) >= cfg_depth[k]) return 1'b0;
    if (busy_m[k]) return 1'b0;
    if (cfg_zero[k] == 1 && wr_addr == 3'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int val_m(int k, int a);
    if (a >= cfg_depth[k]) return 0;
    if (cfg_zero[k] == 1 && a == 0) return 0;
    if (cfg_byp[k] == 1 && legal_m(k) && a == int'(wr_addr)) return int'(wr_data);
    return mem_m[k][a];
  endfunction

  function automatic int exp_rd(int k, int p);
    if (cfg_rreg[k] == 1) return rdq_m[k][p];
    return val_m(k, port_addr(p));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) mem_m[k][i] = 0;
      busy_m[k] = 1'b0;
      ptr_m[k]  = 0;
      drop_m[k] = 1'b0;
      rdq_m[k][0] = 0;
      rdq_m[k][1] = 0;
    end
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 4; k++) begin
        int nq0, nq1;
        bit lg;
        lg  = legal_m(k);
        nq0 = val_m(k, port_addr(0));
        nq1 = val_m(k, port_addr(1));
        drop_m[k] = wr_en && !lg;
        if (lg) mem_m[k][wr_addr] = int'(wr_data);
        if (busy_m[k]) begin
          mem_m[k][ptr_m[k]] = 0;
          ptr_m[k]++;
          if (ptr_m[k] == cfg_depth[k]) begin
            busy_m[k] = 1'b0;
            ptr_m[k]  = 0;
          end
        end else if (clr_req) begin
          busy_m[k] = 1'b1;
          ptr_m[k]  = 0;
        end
        rdq_m[k][0] = nq0;
        rdq_m[k][1] = nq1;
      end
    end
    #1;
  endtask

  task automatic drive(input bit we, input int wa, input int wd,
                       input int r0, input int r1, input bit cr);
    wr_en   = we;
    wr_addr = 3'(wa);
    wr_data = 4'(wd);
    rd_addr = {3'(r1), 3'(r0)};
    clr_req = cr;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Reset held: every address reads zero on every instance, flags low.
  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    for (int a = 0; a < 8; a++) begin
      rd_addr = {3'(7 - a), 3'(a)};
      #1;
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (rd_o[k] !== 8'h00) begin
          n_fail++;
          $display("[TB] FAIL reset_rd dut%0d addr %0d: got %h expected 00", k, a, rd_o[k]);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (busy_o[k] !== 1'b0 || drop_o[k] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_flags dut%0d: got busy=%b drop=%b expected 0/0", k, busy_o[k], drop_o[k]);
      end
    end
    settle();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    drive(1, 3, 'hA, 3, 3, 0);
    settle();
    n_checks++;
    if (port_rd(0, 0) !== 'hA) begin
      n_fail++;
      $display("[TB] FAIL bypass_a3: got %0h expected a", port_rd(0, 0));
    end
    tick();
    drive(0, 0, 0, 3, 3, 0);
    settle();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (port_rd(k, p) !== 'hA) begin
          n_fail++;
          $display("[TB] FAIL read_a3 dut%0d port%0d: got %0h expected a", k, p, port_rd(k, p));
        end
      end
    end
    tick();
    drive(1, 5, 5, 5, 5, 0);
    settle();
    n_checks++;
    if (port_rd(0, 0) !== 5) begin
      n_fail++;
      $display("[TB] FAIL bypass_on: got %0h expected 5", port_rd(0, 0));
    end
    n_checks++;
    if (port_rd(1, 0) !== 0) begin
      n_fail++;
      $display("[TB] FAIL bypass_off_old: got %0h expected 0", port_rd(1, 0));
    end
    tick();
    drive(0, 0, 0, 5, 5, 0);
    settle();
    n_checks++;
    if (port_rd(1, 0) !== 5 || port_rd(1, 1) !== 5) begin
      n_fail++;
      $display("[TB] FAIL bypass_off_next: got %0h/%0h expected 5/5", port_rd(1, 0), port_rd(1, 1));
    end
    tick();
  endtask

  task automatic test_registered();
    drive(0, 0, 0, 0, 0, 0);
    settle();
    tick();
    drive(0, 0, 0, 3, 3, 0);
    settle();
    n_checks++;
    if (port_rd(2, 0) !== 0) begin
      n_fail++;
      $display("[TB] FAIL regread_before: got %0h expected 0", port_rd(2, 0));
    end
    tick();
    settle();
    n_checks++;
    if (port_rd(2, 0) !== 'hA || port_rd(2, 1) !== 'hA) begin
      n_fail++;
      $display("[TB] FAIL regread_after: got %0h/%0h expected a/a", port_rd(2, 0), port_rd(2, 1));
    end
    tick();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 8; i++) begin
      drive(1, i, i + 1, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 7, 2, 1);
    settle();
    tick();
    for (int c = 1; c <= 8; c++) begin
      case (c)
        2:       drive(1, 2, 'hF, 7, 2, 0);
        4:       drive(0, 0, 0, 7, 2, 1);
        default: drive(0, 0, 0, 7, 2, 0);
      endcase
      settle();
      n_checks++;
      if (busy_o[0] !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL clr_busy cycle %0d: got %b expected 1", c, busy_o[0]);
      end
      if (c == 2 || c == 3) begin
        n_checks++;
        if (port_rd(0, 1) !== 3) begin
          n_fail++;
          $display("[TB] FAIL clr_entry2_kept cycle %0d: got %0h expected 3", c, port_rd(0, 1));
        end
      end
      if (c == 3 || c == 4) begin
        n_checks++;
        if (drop_o[0] !== (c == 3)) begin
          n_fail++;
          $display("[TB] FAIL clr_wr_drop cycle %0d: got %b expected %b", c, drop_o[0], c == 3);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (port_rd(0, 0) !== 8) begin
          n_fail++;
          $display("[TB] FAIL clr_addr7_old: got %0h expected 8", port_rd(0, 0));
        end
      end
      tick();
    end
    drive(0, 0, 0, 7, 2, 0);
    settle();
    n_checks++;
    if (busy_o[0] !== 1'b0 || port_rd(0, 0) !== 0 || port_rd(0, 1) !== 0) begin
      n_fail++;
      $display("[TB] FAIL clr_done: got busy=%b rd7=%0h rd2=%0h expected 0/0/0",
               busy_o[0], port_rd(0, 0), port_rd(0, 1));
    end
    tick();
    settle();
    n_checks++;
    if (busy_o[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL clr_no_restart: got %b expected 0", busy_o[0]);
    end
    tick();
  endtask

  task automatic test_zero_depth();
    drive(1, 7, 9, 0, 7, 0);
    settle();
    tick();
    drive(1, 0, 9, 0, 7, 0);
    settle();
    n_checks++;
    if (drop_o[3] !== 1'b1 || drop_o[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL drop_addr7: got z=%b d=%b expected 1/0", drop_o[3], drop_o[0]);
    end
    n_checks++;
    if (port_rd(3, 0) !== 0) begin
      n_fail++;
      $display("[TB] FAIL zero_no_bypass: got %0h expected 0", port_rd(3, 0));
    end
    tick();
    drive(0, 0, 0, 0, 7, 0);
    settle();
    n_checks++;
    if (drop_o[3] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL drop_addr0: got %b expected 1", drop_o[3]);
    end
    n_checks++;
    if (port_rd(3, 0) !== 0 || port_rd(3, 1) !== 0) begin
      n_fail++;
      $display("[TB] FAIL zero_reads: got %0h/%0h expected 0/0", port_rd(3, 0), port_rd(3, 1));
    end
    tick();
    settle();
    n_checks++;
    if (drop_o[3] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL drop_pulse_end: got %b expected 0", drop_o[3]);
    end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < 8; i++) begin
      drive(1, i, 'hC, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 7, 6, 1);
    settle();
    tick();
    drive(0, 0, 0, 7, 6, 0);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (busy_o[k] !== 1'b0 || drop_o[k] !== 1'b0 || rd_o[k] !== 8'h00) begin
        n_fail++;
        $display("[TB] FAIL async_reset dut%0d: got busy=%b drop=%b rd=%h expected 0/0/00",
                 k, busy_o[k], drop_o[k], rd_o[k]);
      end
    end
    settle();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int wa;
      wa = int'($urandom_range(0, 7));
      drive(bit'($urandom_range(0, 1)), wa, int'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 0) ? wa : int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
      settle();
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (busy_o[k] !== busy_m[k] || drop_o[k] !== drop_m[k]) begin
          n_fail++;
          $display("[TB] FAIL rand_flags dut%0d iter %0d: got busy=%b drop=%b expected %b/%b",
                   k, n, busy_o[k], drop_o[k], busy_m[k], drop_m[k]);
        end
        for (int p = 0; p < 2; p++) begin
          n_checks++;
          if (port_rd(k, p) !== exp_rd(k, p)) begin
            n_fail++;
            $display("[TB] FAIL rand_rd dut%0d port%0d iter %0d: got %0h expected %0h",
                     k, p, n, port_rd(k, p), exp_rd(k, p));
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_registered();
    test_clear();
    test_zero_depth();
    test_reset_mid_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
